id_ex_pipe_reg: RTL and testbench
=================================

Name: id_ex_pipe_reg

Overview:
- ID/EX pipeline register sitting directly downstream of the decode stage; feeds the execute stage.
- Latches the decode stage's control word, register read data, sign-extended immediate, PC+4 and register specifiers on every clock.
- Contains load-use hazard detection: it stalls the PC and IF/ID register and inserts a bubble into EX.
- Accepts a flush from branch/jump resolution. Keeps saturating stall and flush event counters for performance debug.

Parameters:
CNT_W, 16, width of the stall and flush event counters (saturating)

Ports:
Clk  input  1  rising-edge clock for all state
Rst  input  1  synchronous active-low reset (Rst==0 at a rising Clk resets the block)
Valid_ID  input  1  ID holds a real instruction
RegWrite_ID, MemtoReg_ID, Branch_ID, MemRead_ID, MemWrite_ID, RegDst_ID, ALUSrc_ID, JR_ID, JAL_ID  input  1 each  decode control bits
ALUOp_ID  input  6  ALU operation code
PCAddResult_ID  input  32  PC+4 of the ID instruction
ReadData1_ID, ReadData2_ID, SignExtResult_ID  input  32 each  operands
rs_ID, rt_ID, rd_ID  input  5 each  register specifiers
Flush  input  1  kill the instruction currently in ID (branch/jump taken)
Stall  output  1  combinational; hold PC and IF/ID this cycle
Valid_EX  output  1  EX holds a real instruction
RegWrite_EX, MemtoReg_EX, Branch_EX, MemRead_EX, MemWrite_EX, RegDst_EX, ALUSrc_EX, JR_EX, JAL_EX  output  1 each  registered control bits
ALUOp_EX  output  6  registered ALU op
PCAddResult_EX, ReadData1_EX, ReadData2_EX, SignExtResult_EX  output  32 each  registered data
rs_EX, rt_EX, rd_EX  output  5 each  registered specifiers
StallCount  output  CNT_W  number of bubbles inserted for load-use
FlushCount  output  CNT_W  number of bubbles inserted for flush

Behaviour:
- Hazard is combinational: `hz = Valid_ID & Valid_EX & MemRead_EX & (rt_EX != 0) & ((rt_EX == rs_ID) | (rt_EX == rt_ID))`.
- `Stall = hz & ~Flush`. A flush kills the ID instruction, so no stall is needed.
- Comparison against rt_ID is deliberately conservative: rt is compared even for I-type instructions that do not read rt.
- Actions at each rising Clk, in priority order:
  1. Rst==0: every registered output is 0, including Valid_EX, StallCount and FlushCount. This applies mid-operation too; Stall becomes 0 in the following cycle because Valid_EX is 0.
  2. Flush==1: insert a bubble (all registered outputs 0, Valid_EX 0). FlushCount increments, saturating at all-ones.
  3. hz==1: insert a bubble. StallCount increments, saturating. ID contents are preserved upstream via Stall, so the instruction is captured on the next cycle.
  4. Otherwise: capture all *_ID inputs into the *_EX outputs, and `Valid_EX <= Valid_ID`.
- A bubble means every control bit is 0: no RegWrite, MemWrite, Branch, JR or JAL. Data fields are also zeroed, so the EX-side view is deterministic.
- When Valid_ID==0 and there is no flush or hazard, the inputs are still captured. Only Valid_EX=0 marks the slot as empty.
- Latency: 1 cycle from ID to EX on the non-stall path.
- A load-use stall lasts exactly 1 cycle. The bubble clears MemRead_EX, so hz deasserts on the next cycle.
- Flush and hz asserted together: the flush wins. Only FlushCount increments and Stall=0.
- Counters stick at 2^CNT_W−1 and do not wrap.

Test Plan:
- Reset: drive all inputs to non-zero values and Rst=0 for 2 clocks -> every output is 0, including both counters and Stall. Release Rst -> the next clock captures the inputs (ALUOp_ID=6'h21 appears on ALUOp_EX).
- Pass-through: issue `add $3,$1,$2` (ReadData1_ID=5, ReadData2_ID=7, rd_ID=3, RegWrite=1) -> one cycle later the EX outputs match exactly, Valid_EX=1 and Stall=0 throughout.
- Load-use: issue `lw $4,0($1)` then `add $5,$4,$2` -> Stall=1 for exactly one cycle and EX sees a bubble (RegWrite_EX=0, Valid_EX=0). The add reaches EX on the following cycle and StallCount=1.
- No false stall: issue `lw $0,...` followed by a reader of $0 -> Stall=0. Issue `lw $4` followed by `add $6,$7,$8` -> Stall=0.
- Flush priority: set up the load-use case, then assert Flush in the hazard cycle -> Stall=0, a bubble is inserted, FlushCount=1 and StallCount is unchanged.
- Saturation: with CNT_W=2, apply 5 consecutive flushes -> FlushCount reads 3 and stays at 3.

Source files
------------

// File: rtl/id_ex_pipe_reg.sv
// ID/EX pipeline register with load-use hazard detection, flush-driven bubbles
// and saturating stall/flush event counters.
module id_ex_pipe_reg #(
    parameter int CNT_W = 16
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic             Valid_ID,
    input  logic             RegWrite_ID,
    input  logic             MemtoReg_ID,
    input  logic             Branch_ID,
    input  logic             MemRead_ID,
    input  logic             MemWrite_ID,
    input  logic             RegDst_ID,
    input  logic             ALUSrc_ID,
    input  logic             JR_ID,
    input  logic             JAL_ID,
    input  logic [5:0]       ALUOp_ID,
    input  logic [31:0]      PCAddResult_ID,
    input  logic [31:0]      ReadData1_ID,
    input  logic [31:0]      ReadData2_ID,
    input  logic [31:0]      SignExtResult_ID,
    input  logic [4:0]       rs_ID,
    input  logic [4:0]       rt_ID,
    input  logic [4:0]       rd_ID,
    input  logic             Flush,
    output logic             Stall,
    output logic             Valid_EX,
    output logic             RegWrite_EX,
    output logic             MemtoReg_EX,
    output logic             Branch_EX,
    output logic             MemRead_EX,
    output logic             MemWrite_EX,
    output logic             RegDst_EX,
    output logic             ALUSrc_EX,
    output logic             JR_EX,
    output logic             JAL_EX,
    output logic [5:0]       ALUOp_EX,
    output logic [31:0]      PCAddResult_EX,
    output logic [31:0]      ReadData1_EX,
    output logic [31:0]      ReadData2_EX,
    output logic [31:0]      SignExtResult_EX,
    output logic [4:0]       rs_EX,
    output logic [4:0]       rt_EX,
    output logic [4:0]       rd_EX,
    output logic [CNT_W-1:0] StallCount,
    output logic [CNT_W-1:0] FlushCount
);

    logic hz;
    logic bubble;

    // rt_ID is compared even when the ID instruction does not read rt; a spare
    // stall is cheaper than decoding which fields are real sources.
    assign hz = Valid_ID & Valid_EX & MemRead_EX & (rt_EX != 5'd0) &
                ((rt_EX == rs_ID) | (rt_EX == rt_ID));

    assign Stall  = hz & ~Flush;
    assign bubble = Flush | hz;

    always_ff @(posedge Clk) begin
        if (!Rst || bubble) begin
            Valid_EX         <= 1'b0;
            RegWrite_EX      <= 1'b0;
            MemtoReg_EX      <= 1'b0;
            Branch_EX        <= 1'b0;
            MemRead_EX       <= 1'b0;
            MemWrite_EX      <= 1'b0;
            RegDst_EX        <= 1'b0;
            ALUSrc_EX        <= 1'b0;
            JR_EX            <= 1'b0;
            JAL_EX           <= 1'b0;
            ALUOp_EX         <= 6'd0;
            PCAddResult_EX   <= 32'd0;
            ReadData1_EX     <= 32'd0;
            ReadData2_EX     <= 32'd0;
            SignExtResult_EX <= 32'd0;
            rs_EX            <= 5'd0;
            rt_EX            <= 5'd0;
            rd_EX            <= 5'd0;
        end else begin
            Valid_EX         <= Valid_ID;
            RegWrite_EX      <= RegWrite_ID;
            MemtoReg_EX      <= MemtoReg_ID;
            Branch_EX        <= Branch_ID;
            MemRead_EX       <= MemRead_ID;
            MemWrite_EX      <= MemWrite_ID;
            RegDst_EX        <= RegDst_ID;
            ALUSrc_EX        <= ALUSrc_ID;
            JR_EX            <= JR_ID;
            JAL_EX           <= JAL_ID;
            ALUOp_EX         <= ALUOp_ID;
            PCAddResult_EX   <= PCAddResult_ID;
            ReadData1_EX     <= ReadData1_ID;
            ReadData2_EX     <= ReadData2_ID;
            SignExtResult_EX <= SignExtResult_ID;
            rs_EX            <= rs_ID;
            rt_EX            <= rt_ID;
            rd_EX            <= rd_ID;
        end
    end

    // Flush takes priority, so a cycle with both events only counts the flush.
    always_ff @(posedge Clk) begin
        if (!Rst) begin
            StallCount <= '0;
            FlushCount <= '0;
        end else if (Flush) begin
            if (FlushCount != '1)
                FlushCount <= FlushCount + CNT_W'(1);
        end else if (hz) begin
            if (StallCount != '1)
                StallCount <= StallCount + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_id_ex_pipe_reg.sv
// Directed bench for id_ex_pipe_reg: reset, pass-through, load-use stall,
// false-stall avoidance, flush priority and counter saturation (CNT_W=2).
module tb_id_ex_pipe_reg;

    localparam int CNT_W = 2;

    logic             Clk = 1'b0;
    logic             Rst;
    logic             Valid_ID;
    logic             RegWrite_ID, MemtoReg_ID, Branch_ID, MemRead_ID, MemWrite_ID;
    logic             RegDst_ID, ALUSrc_ID, JR_ID, JAL_ID;
    logic [5:0]       ALUOp_ID;
    logic [31:0]      PCAddResult_ID, ReadData1_ID, ReadData2_ID, SignExtResult_ID;
    logic [4:0]       rs_ID, rt_ID, rd_ID;
    logic             Flush;
    logic             Stall;
    logic             Valid_EX;
    logic             RegWrite_EX, MemtoReg_EX, Branch_EX, MemRead_EX, MemWrite_EX;
    logic             RegDst_EX, ALUSrc_EX, JR_EX, JAL_EX;
    logic [5:0]       ALUOp_EX;
    logic [31:0]      PCAddResult_EX, ReadData1_EX, ReadData2_EX, SignExtResult_EX;
    logic [4:0]       rs_EX, rt_EX, rd_EX;
    logic [CNT_W-1:0] StallCount, FlushCount;

    int checks   = 0;
    int failures = 0;

    always #5 Clk = ~Clk;

    id_ex_pipe_reg #(.CNT_W(CNT_W)) dut (
        .Clk(Clk), .Rst(Rst), .Valid_ID(Valid_ID),
        .RegWrite_ID(RegWrite_ID), .MemtoReg_ID(MemtoReg_ID), .Branch_ID(Branch_ID),
        .MemRead_ID(MemRead_ID), .MemWrite_ID(MemWrite_ID), .RegDst_ID(RegDst_ID),
        .ALUSrc_ID(ALUSrc_ID), .JR_ID(JR_ID), .JAL_ID(JAL_ID), .ALUOp_ID(ALUOp_ID),
        .PCAddResult_ID(PCAddResult_ID), .ReadData1_ID(ReadData1_ID),
        .ReadData2_ID(ReadData2_ID), .SignExtResult_ID(SignExtResult_ID),
        .rs_ID(rs_ID), .rt_ID(rt_ID), .rd_ID(rd_ID), .Flush(Flush), .Stall(Stall),
        .Valid_EX(Valid_EX), .RegWrite_EX(RegWrite_EX), .MemtoReg_EX(MemtoReg_EX),
        .Branch_EX(Branch_EX), .MemRead_EX(MemRead_EX), .MemWrite_EX(MemWrite_EX),
        .RegDst_EX(RegDst_EX), .ALUSrc_EX(ALUSrc_EX), .JR_EX(JR_EX), .JAL_EX(JAL_EX),
        .ALUOp_EX(ALUOp_EX), .PCAddResult_EX(PCAddResult_EX),
        .ReadData1_EX(ReadData1_EX), .ReadData2_EX(ReadData2_EX),
        .SignExtResult_EX(SignExtResult_EX), .rs_EX(rs_EX), .rt_EX(rt_EX),
        .rd_EX(rd_EX), .StallCount(StallCount), .FlushCount(FlushCount)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Loads one instruction into the ID-side inputs; unlisted controls are 0.
    task automatic set_id(input logic v, input logic rw, input logic mr, input logic mtr,
                          input logic src, input logic [5:0] op, input logic [31:0] pc,
                          input logic [31:0] d1, input logic [31:0] d2,
                          input logic [31:0] imm, input logic [4:0] rs,
                          input logic [4:0] rt, input logic [4:0] rd);
        Valid_ID = v;     RegWrite_ID = rw;  MemRead_ID = mr;   MemtoReg_ID = mtr;
        ALUSrc_ID = src;  RegDst_ID = ~src;  Branch_ID = 1'b0;  MemWrite_ID = 1'b0;
        JR_ID = 1'b0;     JAL_ID = 1'b0;     ALUOp_ID = op;     PCAddResult_ID = pc;
        ReadData1_ID = d1; ReadData2_ID = d2; SignExtResult_ID = imm;
        rs_ID = rs;       rt_ID = rt;        rd_ID = rd;
    endtask

    task automatic step;
        @(posedge Clk);
        #1;
    endtask

    task automatic lw4;
        set_id(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 6'h23, 32'h200, 32'h40, 32'h0, 32'h0, 5'd1, 5'd4, 5'd0);
    endtask

    task automatic add_dep;
        set_id(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 6'h20, 32'h204, 32'h9, 32'h7, 32'h0, 5'd4, 5'd2, 5'd5);
    endtask

    initial begin
        // Reset with every input non-zero
        @(negedge Clk);
        Rst = 1'b0; Flush = 1'b0;
        Valid_ID = 1'b1; RegWrite_ID = 1'b1; MemtoReg_ID = 1'b1; Branch_ID = 1'b1;
        MemRead_ID = 1'b1; MemWrite_ID = 1'b1; RegDst_ID = 1'b1; ALUSrc_ID = 1'b1;
        JR_ID = 1'b1; JAL_ID = 1'b1; ALUOp_ID = 6'h21; PCAddResult_ID = 32'h1004;
        ReadData1_ID = 32'hAAAA; ReadData2_ID = 32'h5555; SignExtResult_ID = 32'hFFFF_FFF0;
        rs_ID = 5'd1; rt_ID = 5'd2; rd_ID = 5'd3;
        step; step;
        chk("rst_valid", {31'd0, Valid_EX}, 32'd0);
        chk("rst_ctrl", {23'd0, RegWrite_EX, MemtoReg_EX, Branch_EX, MemRead_EX, MemWrite_EX,
                         RegDst_EX, ALUSrc_EX, JR_EX, JAL_EX}, 32'd0);
        chk("rst_aluop", {26'd0, ALUOp_EX}, 32'd0);
        chk("rst_data", ReadData1_EX | ReadData2_EX | SignExtResult_EX | PCAddResult_EX, 32'd0);
        chk("rst_regs", {17'd0, rs_EX, rt_EX, rd_EX}, 32'd0);
        chk("rst_cnt", {28'd0, StallCount, FlushCount}, 32'd0);
        chk("rst_stall", {31'd0, Stall}, 32'd0);

        @(negedge Clk);
        Rst = 1'b1;
        step;
        chk("rel_aluop", {26'd0, ALUOp_EX}, 32'h21);
        chk("rel_valid", {31'd0, Valid_EX}, 32'd1);
        chk("rel_pc", PCAddResult_EX, 32'h1004);

        // Empty slot to clear the pipe
        @(negedge Clk);
        set_id(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 6'h0, 32'h0, 32'h0, 32'h0, 32'h0, 5'd0, 5'd0, 5'd0);
        step;
        chk("empty_valid", {31'd0, Valid_EX}, 32'd0);

        // add $3,$1,$2
        @(negedge Clk);
        set_id(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 6'h20, 32'h104, 32'd5, 32'd7, 32'h0, 5'd1, 5'd2, 5'd3);
        #1 chk("add_stall", {31'd0, Stall}, 32'd0);
        step;
        chk("add_rd1", ReadData1_EX, 32'd5);
        chk("add_rd2", ReadData2_EX, 32'd7);
        chk("add_rd", {27'd0, rd_EX}, 32'd3);
        chk("add_rw", {31'd0, RegWrite_EX}, 32'd1);
        chk("add_valid", {31'd0, Valid_EX}, 32'd1);
        chk("add_pc", PCAddResult_EX, 32'h104);
        chk("add_op", {26'd0, ALUOp_EX}, 32'h20);

        // lw $4 ; add $5,$4,$2
        @(negedge Clk);
        lw4();
        #1 chk("lw_stall", {31'd0, Stall}, 32'd0);
        step;
        chk("lw_mr", {31'd0, MemRead_EX}, 32'd1);
        @(negedge Clk);
        add_dep();
        #1 chk("lu_stall", {31'd0, Stall}, 32'd1);
        step;
        chk("lu_bub_valid", {31'd0, Valid_EX}, 32'd0);
        chk("lu_bub_rw", {31'd0, RegWrite_EX}, 32'd0);
        chk("lu_scnt", {30'd0, StallCount}, 32'd1);
        chk("lu_stall_off", {31'd0, Stall}, 32'd0);
        step;
        chk("lu_add_valid", {31'd0, Valid_EX}, 32'd1);
        chk("lu_add_rd", {27'd0, rd_EX}, 32'd5);
        chk("lu_add_rs", {27'd0, rs_EX}, 32'd4);
        chk("lu_add_rw", {31'd0, RegWrite_EX}, 32'd1);

        // lw $0 ; reader of $0
        @(negedge Clk);
        set_id(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 6'h23, 32'h300, 32'h0, 32'h0, 32'h0, 5'd1, 5'd0, 5'd0);
        step;
        @(negedge Clk);
        set_id(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 6'h20, 32'h304, 32'h0, 32'h0, 32'h0, 5'd0, 5'd0, 5'd9);
        #1 chk("r0_stall", {31'd0, Stall}, 32'd0);
        step;
        chk("r0_rd", {27'd0, rd_EX}, 32'd9);

        // lw $4 ; add $6,$7,$8
        @(negedge Clk);
        lw4();
        step;
        @(negedge Clk);
        set_id(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 6'h20, 32'h208, 32'h1, 32'h2, 32'h0, 5'd7, 5'd8, 5'd6);
        #1 chk("nodep_stall", {31'd0, Stall}, 32'd0);
        step;
        chk("nodep_valid", {31'd0, Valid_EX}, 32'd1);
        chk("nodep_rd", {27'd0, rd_EX}, 32'd6);
        chk("nodep_scnt", {30'd0, StallCount}, 32'd1);

        // Flush in the hazard cycle
        @(negedge Clk);
        lw4();
        step;
        @(negedge Clk);
        add_dep();
        Flush = 1'b1;
        #1 chk("fl_stall", {31'd0, Stall}, 32'd0);
        step;
        chk("fl_valid", {31'd0, Valid_EX}, 32'd0);
        chk("fl_rw", {31'd0, RegWrite_EX}, 32'd0);
        chk("fl_rd1", ReadData1_EX, 32'd0);
        chk("fl_fcnt", {30'd0, FlushCount}, 32'd1);
        chk("fl_scnt", {30'd0, StallCount}, 32'd1);

        // Four more flushes: 2, 3, then held at 3
        for (int i = 2; i <= 5; i++) begin
            step;
            chk($sformatf("sat_fcnt_%0d", i), {30'd0, FlushCount}, (i > 3) ? 32'd3 : i);
        end
        @(negedge Clk);
        Flush = 1'b0;

        // Reset in the middle of a load-use hazard
        lw4();
        step;
        @(negedge Clk);
        add_dep();
        Rst = 1'b0;
        #1 chk("mr_stall_pre", {31'd0, Stall}, 32'd1);
        step;
        chk("mr_cnt", {28'd0, StallCount, FlushCount}, 32'd0);
        chk("mr_valid", {31'd0, Valid_EX}, 32'd0);
        chk("mr_stall_post", {31'd0, Stall}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
